// File: rtl/dmem_if.sv
// Load/store interface between the core memory stage and a req/ack data memory.
// Formats byte enables and store lanes, extends load data, and reports misaligned, illegal and timed-out accesses.
module dmem_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic            TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = we;   // unsigned stores do not exist
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Only meaningful once the funct3 is known to be legal.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] d;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  d = {{24{sh[7]}}, sh[7:0]};
            3'b001:  d = {{16{sh[15]}}, sh[15:0]};
            3'b100:  d = {24'd0, sh[7:0]};
            3'b101:  d = {16'd0, sh[15:0]};
            default: d = rd;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic req_ill, req_mis, can_accept, go, bad;

    assign req_ill    = f3_illegal(req_funct3_i, req_we_i);
    assign req_mis    = is_misaligned(req_funct3_i, req_addr_i[1:0]);
    assign can_accept = (state_q != BUSY) && req_valid_i;
    assign go         = can_accept && !req_ill && !req_mis;
    assign bad        = can_accept && (req_ill || req_mis);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (go) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    f3_d    = req_funct3_i;
                    off_d   = req_addr_i[1:0];
                    we_d    = req_we_i;
                    be_d    = lane_be(req_funct3_i, req_addr_i[1:0]);
                    addr_d  = {req_addr_i[31:2], 2'b00};
                    wdata_d = store_lanes(req_funct3_i, req_wdata_i);
                end else if (bad) begin
                    err_d  = 1'b1;
                    code_d = req_ill ? ERR_ILLEGAL : ERR_MISALIGN;
                end
            end
            BUSY: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack_i) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = load_extract(f3_q, off_q, mem_rdata_i);
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Gated by reset so a request held during reset cannot raise the stall.
    assign stall_o       = rst_n_i && ((state_q == BUSY) || go);
    assign mem_req_o     = (state_q == BUSY);
    assign mem_we_o      = we_q;
    assign mem_be_o      = be_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = (state_q == RESP) && !we_q;
    assign err_o         = err_q;
    assign err_code_o    = code_q;

endmodule

// File: tb/tb_dmem_if.sv
// Bench for dmem_if with a 4-cycle timeout: directed test-plan steps followed by random transactions
// checked against a byte-level arithmetic reference model.
module tb_dmem_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_code  = '0;

    dmem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .stall_o      (stall),
        .rdata_o      (rdata),
        .rdata_valid_o(rdata_valid),
        .err_o        (err),
        .err_code_o   (err_code),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: access size in bytes and byte-wise arithmetic.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6 || (f3 >= 3'd4 && we)) return 2'd3;
        if ((a % nbytes(f3)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wd >> (8 * (i % nbytes(f3))));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int     n;
        n = nbytes(f3);
        v = longint'(rd >> (8 * (a % 4)));
        v = v & ((longint'(1) << (8 * n)) - 1);
        if (f3[2] == 1'b0 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One transaction; dly = cycles after mem_req rises before ack (>=4 means never).
    // Returns in the RESP cycle, the error-pulse cycle, or the timeout-error cycle.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly);
        logic [1:0] ec;
        logic       acked;
        ec         = m_err(we, f3, a);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        chk("stall_accept", 32'(stall), 32'(ec == 2'd0));
        chk("req_accept", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        #1;
        if (ec != 2'd0) begin
            exp_code = ec;
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_code", 32'(err_code), 32'(ec));
            chk("err_stall", 32'(stall), 32'd0);
            chk("err_req", 32'(mem_req), 32'd0);
            chk("err_rvalid", 32'(rdata_valid), 32'd0);
            return;
        end
        acked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_we", 32'(mem_we), 32'(we));
            chk("busy_be", 32'(mem_be), 32'(m_be(f3, a)));
            chk("busy_addr", mem_addr, a & ~32'd3);
            if (we) chk("busy_wdata", mem_wdata, m_wdata(f3, wd));
            mem_ack   = (k == dly);
            mem_rdata = (k == dly) ? rd : $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            #1;
            if (k == dly) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) begin
            exp_code = 2'd2;
            chk("to_err", 32'(err), 32'd1);
            chk("to_code", 32'(err_code), 32'd2);
            chk("to_stall", 32'(stall), 32'd0);
            chk("to_req", 32'(mem_req), 32'd0);
            chk("to_rvalid", 32'(rdata_valid), 32'd0);
            return;
        end
        if (!we) exp_rdata = m_load(f3, a, rd);
        chk("resp_rvalid", 32'(rdata_valid), 32'(!we));
        chk("resp_rdata", rdata, exp_rdata);
        chk("resp_stall", 32'(stall), 32'd0);
        chk("resp_req", 32'(mem_req), 32'd0);
        chk("resp_err", 32'(err), 32'd0);
        chk("resp_code", 32'(err_code), 32'(exp_code));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #2;
        chk("idle_rvalid", 32'(rdata_valid), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 0);
        chk("lb_const", rdata, 32'hFFFF_FF80);
        idle_cycle();
        txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1);
        chk("lhu_const", rdata, 32'h0000_BEEF);
        idle_cycle();
        txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 2);
        chk("lh_const", rdata, 32'hFFFF_BEEF);
        idle_cycle();
        txn(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0, 0);
        chk("sb_keeps_rdata", rdata, 32'hFFFF_BEEF);
        idle_cycle();
        txn(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0);
        idle_cycle();
        txn(1'b1, 3'b011, 32'h0000_4000, 32'h1234_5678, 32'h0, 0);
        idle_cycle();
        txn(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 9);
        txn(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 0);
        // Back-to-back: next request presented in the RESP cycle.
        txn(1'b0, 3'b100, 32'h0000_6001, 32'h0, 32'h1234_9A78, 3);
        idle_cycle();

        // Ack outside BUSY must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_rvalid", 32'(rdata_valid), 32'd0);
        chk("stray_ack_rdata", rdata, exp_rdata);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            txn(1'($urandom), f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset during BUSY.
        txn(1'b1, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_7000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        exp_code  = '0;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_code", 32'(err_code), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
